// File: rtl/mem_port_scheduler_pkg.sv
// Shared types for the data-memory port scheduler: FSM states, access sizes
// and the store queue entry payload.
package mem_port_scheduler_pkg;

    localparam int unsigned ADDRESS_WIDTH  = 64;
    localparam int unsigned REGISTER_WIDTH = 64;
    localparam int unsigned SIZE_WIDTH     = 2;
    localparam int unsigned DWORD_OFFSET   = 3;
    localparam int unsigned TAG_WIDTH      = ADDRESS_WIDTH - DWORD_OFFSET;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } port_state_e;

    localparam logic [SIZE_WIDTH-1:0] SZ_B = 2'd0;
    localparam logic [SIZE_WIDTH-1:0] SZ_H = 2'd1;
    localparam logic [SIZE_WIDTH-1:0] SZ_W = 2'd2;
    localparam logic [SIZE_WIDTH-1:0] SZ_D = 2'd3;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0]  addr;
        logic [REGISTER_WIDTH-1:0] data;
        logic [SIZE_WIDTH-1:0]     size;
    } sq_entry_t;

endpackage

// File: rtl/mem_port_scheduler_store_queue.sv
// In-order FIFO of committed stores; also reports which valid entries share a
// doubleword with the pending load address.
module mem_port_scheduler_store_queue
    import mem_port_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  sq_entry_t            push_entry,
    input  logic                 pop,
    output sq_entry_t            head_entry,
    output logic [PTR_WIDTH:0]   count,
    input  logic [TAG_WIDTH-1:0] match_tag,
    output logic [DEPTH-1:0]     match
);

    sq_entry_t              entries [DEPTH];
    logic [DEPTH-1:0]       valid;
    logic [PTR_WIDTH-1:0]   head;
    logic [PTR_WIDTH-1:0]   tail;

    // Payload storage carries no reset; occupancy is tracked by valid bits.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_WIDTH'(1);
            end
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_WIDTH+1)'(1);
                2'b01:   count <= count - (PTR_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_entry = entries[head];

    // An entry stays valid while in flight, so a load cannot overtake it.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (entries[i].addr[ADDRESS_WIDTH-1:DWORD_OFFSET] == match_tag);
        end
    end

endmodule

// File: rtl/mem_port_scheduler.sv
// Arbitrates the single data-memory port between the load path and the
// buffered writeback stores, with a drain-and-acknowledge flush for ecalls.
module mem_port_scheduler
    import mem_port_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned PTR_WIDTH       = 2,
    parameter int unsigned LOAD_STREAK_MAX = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      st_valid,
    input  logic [ADDRESS_WIDTH-1:0]  st_addr,
    input  logic [REGISTER_WIDTH-1:0] st_data,
    input  logic [SIZE_WIDTH-1:0]     st_size,
    output logic                      st_ready,
    input  logic                      ld_valid,
    input  logic [ADDRESS_WIDTH-1:0]  ld_addr,
    output logic                      ld_done,
    input  logic                      flush_req,
    output logic                      flush_done,
    output logic                      mem_req_valid,
    output logic                      mem_req_write,
    output logic [ADDRESS_WIDTH-1:0]  mem_req_addr,
    output logic [REGISTER_WIDTH-1:0] mem_req_data,
    output logic [SIZE_WIDTH-1:0]     mem_req_size,
    input  logic                      mem_req_ready,
    input  logic                      mem_done,
    output logic [PTR_WIDTH:0]        sq_count
);

    localparam int unsigned COUNT_WIDTH  = PTR_WIDTH + 1;
    localparam int unsigned STREAK_WIDTH = $clog2(LOAD_STREAK_MAX + 1);

    port_state_e             state;
    logic                    flush_pending;
    logic [STREAK_WIDTH-1:0] streak;

    sq_entry_t               st_entry;
    sq_entry_t               sq_head;
    logic [DEPTH-1:0]        sq_match;
    logic                    sq_push;
    logic                    sq_pop;
    logic                    sq_full;
    logic                    sq_empty;
    logic                    ld_conflict;
    logic                    flush_active;
    logic                    flush_fire;
    logic                    pick_store;
    logic                    pick_load;

    assign st_entry = '{addr: st_addr, data: st_data, size: st_size};

    assign sq_full  = (sq_count == COUNT_WIDTH'(DEPTH));
    assign sq_empty = (sq_count == '0);
    assign st_ready = !sq_full && !flush_pending;
    assign sq_push  = st_valid && st_ready;
    assign sq_pop   = (state == WAIT) && mem_done && mem_req_write;

    mem_port_scheduler_store_queue #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_store_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (sq_push),
        .push_entry (st_entry),
        .pop        (sq_pop),
        .head_entry (sq_head),
        .count      (sq_count),
        .match_tag  (ld_addr[ADDRESS_WIDTH-1:DWORD_OFFSET]),
        .match      (sq_match)
    );

    // A flush arriving this cycle already counts, so an empty idle port acks next cycle.
    assign flush_active = flush_pending || flush_req;
    assign flush_fire   = flush_active && sq_empty;
    assign ld_conflict  = |sq_match;

    assign pick_store = !sq_empty &&
                        (sq_full || (streak == STREAK_WIDTH'(LOAD_STREAK_MAX)) ||
                         flush_active || !ld_valid || ld_conflict);
    assign pick_load  = ld_valid && !flush_active && !pick_store;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            flush_pending <= 1'b0;
            streak        <= '0;
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            mem_req_size  <= '0;
            ld_done       <= 1'b0;
            flush_done    <= 1'b0;
        end else begin
            ld_done    <= 1'b0;
            flush_done <= 1'b0;
            if (flush_req) begin
                flush_pending <= 1'b1;
            end
            if (sq_empty) begin
                streak <= '0;
            end
            case (state)
                IDLE: begin
                    if (flush_fire) begin
                        flush_done    <= 1'b1;
                        flush_pending <= 1'b0;
                    end else if (pick_store) begin
                        mem_req_valid <= 1'b1;
                        mem_req_write <= 1'b1;
                        mem_req_addr  <= sq_head.addr;
                        mem_req_data  <= sq_head.data;
                        mem_req_size  <= sq_head.size;
                        streak        <= '0;
                        state         <= REQ;
                    end else if (pick_load) begin
                        mem_req_valid <= 1'b1;
                        mem_req_write <= 1'b0;
                        mem_req_addr  <= ld_addr;
                        mem_req_data  <= '0;
                        mem_req_size  <= SZ_B;
                        if (!sq_empty) begin
                            streak <= streak + STREAK_WIDTH'(1);
                        end
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // Store pops happen in the queue on the same mem_done.
                    if (mem_done) begin
                        ld_done <= !mem_req_write;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed bench for mem_port_scheduler with a one-cycle memory responder and
// a log of every accepted memory request.
module tb_mem_port_scheduler;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic [1:0]  st_size;
    logic        st_ready;
    logic        ld_valid;
    logic [63:0] ld_addr;
    logic        ld_done;
    logic        flush_req;
    logic        flush_done;
    logic        mem_req_valid;
    logic        mem_req_write;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_data;
    logic [1:0]  mem_req_size;
    logic        mem_req_ready;
    logic        mem_done;
    logic [2:0]  sq_count;

    int checks;
    int failures;
    int ld_done_cnt;
    int flush_done_cnt;
    int flush_log_len;
    int flush_sq;
    logic ld_stream;

    logic        log_write [$];
    logic [63:0] log_addr  [$];
    logic [63:0] log_data  [$];
    logic [1:0]  log_size  [$];

    mem_port_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .st_valid      (st_valid),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .st_size       (st_size),
        .st_ready      (st_ready),
        .ld_valid      (ld_valid),
        .ld_addr       (ld_addr),
        .ld_done       (ld_done),
        .flush_req     (flush_req),
        .flush_done    (flush_done),
        .mem_req_valid (mem_req_valid),
        .mem_req_write (mem_req_write),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_size  (mem_req_size),
        .mem_req_ready (mem_req_ready),
        .mem_done      (mem_done),
        .sq_count      (sq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] log_a(input int i);
        return (i < log_addr.size()) ? log_addr[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic logic [63:0] log_w(input int i);
        return (i < log_write.size()) ? 64'(log_write[i]) : 64'hF;
    endfunction

    function automatic logic [63:0] log_d(input int i);
        return (i < log_data.size()) ? log_data[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic logic [63:0] log_s(input int i);
        return (i < log_size.size()) ? 64'(log_size[i]) : 64'hF;
    endfunction

    task automatic clear_log();
        log_write.delete();
        log_addr.delete();
        log_data.delete();
        log_size.delete();
    endtask

    // One clock: log a handshake, answer it with mem_done next cycle, react to pulses.
    task automatic tick();
        logic acc;
        acc = mem_req_valid && mem_req_ready;
        if (acc) begin
            log_write.push_back(mem_req_write);
            log_addr.push_back(mem_req_addr);
            log_data.push_back(mem_req_data);
            log_size.push_back(mem_req_size);
        end
        @(posedge clk);
        #1;
        mem_done = acc;
        if (ld_done) begin
            ld_done_cnt++;
            if (ld_stream) ld_addr = ld_addr + 64'h10;
            else           ld_valid = 1'b0;
        end
        if (flush_done) begin
            flush_done_cnt++;
            flush_log_len = log_addr.size();
            flush_sq      = 32'(sq_count);
        end
    endtask

    task automatic push_store(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = s;
        tick();
        st_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; ld_done_cnt = 0; flush_done_cnt = 0;
        flush_log_len = -1; flush_sq = -1; ld_stream = 1'b0;
        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
        ld_valid = 1'b0; ld_addr = '0; flush_req = 1'b0;
        mem_req_ready = 1'b0; mem_done = 1'b0;
        tick(); tick();
        check("rst_valid", 64'(mem_req_valid), 64'd0);
        check("rst_count", 64'(sq_count), 64'd0);
        check("rst_ld_done", 64'(ld_done), 64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);
        reset = 1'b0;
        tick();
        check("rst_st_ready", 64'(st_ready), 64'd1);

        // Idle load: request one cycle after ld_valid, ld_done three cycles after.
        clear_log();
        ld_valid = 1'b1; ld_addr = 64'h100; mem_req_ready = 1'b1;
        tick();
        check("ld_req_valid", 64'(mem_req_valid), 64'd1);
        check("ld_req_write", 64'(mem_req_write), 64'd0);
        check("ld_req_addr", mem_req_addr, 64'h100);
        check("ld_req_size", 64'(mem_req_size), 64'd0);
        check("ld_req_data", mem_req_data, 64'd0);
        tick();
        check("ld_accept_drop", 64'(mem_req_valid), 64'd0);
        check("ld_done_early", 64'(ld_done), 64'd0);
        tick();
        check("ld_done_pulse", 64'(ld_done), 64'd1);
        check("ld_count", 64'(sq_count), 64'd0);
        tick();
        check("ld_done_clear", 64'(ld_done), 64'd0);
        check("ld_no_reissue", 64'(mem_req_valid), 64'd0);
        check("ld_log_len", 64'(log_addr.size()), 64'd1);

        // Store drain order, sq_count 2 -> 1 -> 0.
        clear_log();
        push_store(64'h200, 64'hAA, 2'd3);
        check("sd_count1", 64'(sq_count), 64'd1);
        push_store(64'h300, 64'hBB, 2'd2);
        check("sd_count2", 64'(sq_count), 64'd2);
        tick(); tick();
        check("sd_count_after1", 64'(sq_count), 64'd1);
        tick(); tick(); tick();
        check("sd_count_after2", 64'(sq_count), 64'd0);
        check("sd_log_len", 64'(log_addr.size()), 64'd2);
        check("sd0_write", log_w(0), 64'd1);
        check("sd0_addr", log_a(0), 64'h200);
        check("sd0_size", log_s(0), 64'd3);
        check("sd0_data", log_d(0), 64'hAA);
        check("sd1_addr", log_a(1), 64'h300);
        check("sd1_size", log_s(1), 64'd2);
        check("sd1_data", log_d(1), 64'hBB);

        // Full queue: fifth store refused until one entry completes.
        clear_log();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_store(64'h1000 + 64'(i) * 64'h10, 64'(i + 1), 2'd3);
        end
        st_valid = 1'b1; st_addr = 64'h1040; st_data = 64'h5; st_size = 2'd3;
        check("full_count", 64'(sq_count), 64'd4);
        check("full_st_ready", 64'(st_ready), 64'd0);
        tick();
        check("full_no_push", 64'(sq_count), 64'd4);
        check("full_req_hold", mem_req_addr, 64'h1000);
        check("full_req_valid", 64'(mem_req_valid), 64'd1);
        st_valid = 1'b0; mem_req_ready = 1'b1;
        tick(); tick();
        check("full_after_pop", 64'(sq_count), 64'd3);
        check("full_ready_again", 64'(st_ready), 64'd1);
        repeat (20) tick();
        check("full_drained", 64'(sq_count), 64'd0);
        check("full_log_len", 64'(log_addr.size()), 64'd4);
        check("full_first_data", log_d(0), 64'd1);
        check("full_last_addr", log_a(3), 64'h1030);

        // Conflict: same-doubleword load waits behind the younger store too.
        for (int v = 0; v < 2; v++) begin
            clear_log();
            ld_done_cnt = 0;
            mem_req_ready = 1'b0;
            push_store(64'h408, 64'h11, 2'd3);
            push_store(64'h40C, 64'h22, 2'd2);
            ld_valid = 1'b1;
            ld_addr  = (v == 0) ? 64'h40C : 64'h500;
            tick(); tick();
            check("cf_hold_addr", mem_req_addr, 64'h408);
            mem_req_ready = 1'b1;
            repeat (25) tick();
            check("cf_log_len", 64'(log_addr.size()), 64'd3);
            check("cf_ld_done", 64'(ld_done_cnt), 64'd1);
            check("cf0_addr", log_a(0), 64'h408);
            if (v == 0) begin
                check("cf_blk1_write", log_w(1), 64'd1);
                check("cf_blk1_addr", log_a(1), 64'h40C);
                check("cf_blk2_write", log_w(2), 64'd0);
                check("cf_blk2_addr", log_a(2), 64'h40C);
            end else begin
                check("cf_free1_write", log_w(1), 64'd0);
                check("cf_free1_addr", log_a(1), 64'h500);
                check("cf_free2_write", log_w(2), 64'd1);
                check("cf_free2_addr", log_a(2), 64'h40C);
            end
        end

        // Starvation: four load grants with a store waiting, then the store.
        clear_log();
        mem_req_ready = 1'b0;
        ld_stream = 1'b1; ld_valid = 1'b1; ld_addr = 64'h2000;
        tick();
        push_store(64'h800, 64'h77, 2'd3);
        mem_req_ready = 1'b1;
        repeat (24) tick();
        ld_stream = 1'b0;
        repeat (12) tick();
        check("stv_len", 64'(log_addr.size() >= 6), 64'd1);
        check("stv_l0", log_a(0), 64'h2000);
        check("stv_l4_write", log_w(4), 64'd0);
        check("stv_l4_addr", log_a(4), 64'h2040);
        check("stv_st_write", log_w(5), 64'd1);
        check("stv_st_addr", log_a(5), 64'h800);
        check("stv_ld_after", log_w(6), 64'd0);
        check("stv_count", 64'(sq_count), 64'd0);

        // Flush: drain three stores, one ack, then the held load.
        clear_log();
        mem_req_ready = 1'b0;
        push_store(64'h900, 64'h1, 2'd3);
        push_store(64'h910, 64'h2, 2'd3);
        push_store(64'h920, 64'h3, 2'd3);
        flush_req = 1'b1; ld_valid = 1'b1; ld_addr = 64'hA00;
        tick();
        flush_req = 1'b0;
        check("fl_st_ready", 64'(st_ready), 64'd0);
        check("fl_count", 64'(sq_count), 64'd3);
        flush_done_cnt = 0;
        mem_req_ready = 1'b1;
        repeat (30) tick();
        check("fl_done_once", 64'(flush_done_cnt), 64'd1);
        check("fl_done_after_stores", 64'(flush_log_len), 64'd3);
        check("fl_done_empty", 64'(flush_sq), 64'd0);
        check("fl_log_len", 64'(log_addr.size()), 64'd4);
        check("fl_st2_addr", log_a(2), 64'h920);
        check("fl_ld_write", log_w(3), 64'd0);
        check("fl_ld_addr", log_a(3), 64'hA00);
        check("fl_st_ready_after", 64'(st_ready), 64'd1);

        // Flush with an empty idle port acknowledges on the next cycle.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check("fl_empty_done", 64'(flush_done), 64'd1);
        tick();
        check("fl_empty_clear", 64'(flush_done), 64'd0);

        // Reset in REQ abandons the request; a stray mem_done is ignored.
        mem_req_ready = 1'b0;
        push_store(64'hB00, 64'h9, 2'd3);
        tick();
        check("mr_req_valid", 64'(mem_req_valid), 64'd1);
        check("mr_count", 64'(sq_count), 64'd1);
        reset = 1'b1;
        tick();
        check("mr_valid_cleared", 64'(mem_req_valid), 64'd0);
        check("mr_count_cleared", 64'(sq_count), 64'd0);
        reset = 1'b0;
        mem_done = 1'b1;
        tick();
        check("mr_stray_ld_done", 64'(ld_done), 64'd0);
        check("mr_stray_valid", 64'(mem_req_valid), 64'd0);
        check("mr_stray_count", 64'(sq_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
